scroll_text14: RTL
==================

SCROLL_TEXT14 -- requirements
Module: scroll_text14

Interface
REQ-001 Parameter: DIGITS, 12, number of multiplexed 14-segment digits.
REQ-002 Parameter: MSG_DEPTH, 32, message buffer entries.
REQ-003 Parameter: DIV_W, 16, width of the scroll-step divider.
REQ-004 Power pins: vdd and vss, inout, present only under USE_POWER_PINS.
REQ-005 Port: clk  in  1  sole clock; all logic on the rising edge.
REQ-006 Port: rst  in  1  synchronous, active-high reset.
REQ-007 Port: wr_en  in  1  write strobe for the message buffer.
REQ-008 Port: wr_addr  in  5  message buffer write address.
REQ-009 Port: wr_char  in  6  character code to write.
REQ-010 Port: msg_len  in  6  active message length; 0 = blank display; values above 32 clamp to 32.
REQ-011 Port: scroll_en  in  1  1 = scroll; 0 = freeze the current offset.
REQ-012 Port: step_div  in  DIV_W  frames per scroll step, minus 1.
REQ-013 Port: sel  out  12  one-hot digit select; bit k = digit k.
REQ-014 Port: segm  out  14  segment pattern; same bit order as the existing display glyphs.
REQ-015 Port: frame_start  out  1  one-cycle pulse coincident with sel bit 0.

Function
REQ-016 Character codes SHALL be:
  - 0 = space (all segments off)
  - 1-26 = A-Z
  - 27-36 = digits 0-9
  - 37-63 = blank
REQ-017 Glyph values SHALL match the team font, e.g. A=11101111000000, E=10011110000000, T=10000000010010.
REQ-018 A 4-bit digit counter SHALL advance once per clock, 0..11, wrapping 11->0; one frame = 12 cycles.
REQ-019 sel and segm SHALL be registered, with exactly one cycle of latency from digit counter k to sel = 1<<k.
REQ-020 Digit k SHALL show glyph(msg[(offset+k) mod L]), where L = the clamped msg_len.
REQ-021 If L < 12, the message SHALL repeat across the digits through the modulo.
REQ-022 If L = 0, segm SHALL be all zeros while sel keeps scanning.
REQ-023 A frame counter SHALL count completed frames.
REQ-024 When scroll_en=1 and frame counter >= step_div:
  - offset <= (offset+1) mod L
  - frame counter <= 0
REQ-025 offset and the frame counter SHALL update only on the digit-counter 11->0 wrap, so no frame is ever torn.
REQ-026 When scroll_en=0, offset and the frame counter SHALL hold.
REQ-027 If offset >= L after msg_len shrinks, offset SHALL load 0 at the next frame boundary.
REQ-028 Writes SHALL take effect on the clock edge.
REQ-029 A read of the same address in the same cycle as a write SHALL return the old value; the new character SHALL be visible no later than the next frame.
REQ-030 wr_addr values beyond MSG_DEPTH-1 are not possible at 5 bits; all 32 entries SHALL be writable regardless of msg_len.
REQ-031 Lowering step_div below the current frame count SHALL step at the next frame boundary.

Reset
REQ-032 While rst=1, the following SHALL load on each clock edge:
  - sel=0, segm=0, frame_start=0
  - digit counter=0, offset=0, frame counter=0
  - all message entries = 0 (space)
REQ-033 A write asserted together with rst SHALL be ignored.
REQ-034 On the first edge with rst=0, the digit counter SHALL be 0.
REQ-035 On the second edge with rst=0, outputs SHALL be sel=000000000001 and frame_start=1.
REQ-036 Reset asserted mid-frame SHALL abort the frame with no partial-state carry-over.

Structure
REQ-037 Package scroll14_pkg SHALL hold:
  - character-code constants (CH_SPACE, CH_A, CH_0)
  - DIGITS
  - MSG_DEPTH
  - the 14-bit glyph constants
REQ-038 Sub-module font14 SHALL be a purely combinational map from 6-bit code to 14-bit glyph.
REQ-039 The message buffer SHALL be a flop array, not an SRAM macro.
REQ-040 The top SHALL remain sta-blackboxable like the other display blocks.

Verification
REQ-041 Static E-S-Q-U: reset, write codes 5,19,17,21 to addresses 0-3, msg_len=4, scroll_en=0 -> sel bits 0..11 show E,S,Q,U repeated three times each frame.
REQ-042 Scroll step: msg_len=12, step_div=2, scroll_en=1 -> offset increments every 3 frames (36 cycles); after 12 steps it returns to 0.
REQ-043 Blank: msg_len=0 -> segm=0 for all 12 digits; sel still walks one-hot with period 12.
REQ-044 Shrink: offset=10, change msg_len from 16 to 8 mid-frame -> the current frame is unchanged; the next frame starts at offset 0.
REQ-045 Write during scan: overwrite address 0 (currently shown at digit 0) with code 1 -> A=11101111000000 appears on digit 0 within one frame; no other digit changes.
REQ-046 Reset mid-frame at digit 7 -> sel=0 and segm=0 during reset; the first post-reset output is sel bit 0 with segm=0 (space).

Source files
------------

// File: rtl/scroll14_pkg.sv
// Shared constants for the 14-segment scrolling text display.
// Glyph bit order (MSB..LSB): a b c d e f g1 g2 h i j k l m.
package scroll14_pkg;

  localparam int DIGITS    = 12;
  localparam int MSG_DEPTH = 32;

  localparam logic [5:0] CH_SPACE = 6'd0;
  localparam logic [5:0] CH_A     = 6'd1;
  localparam logic [5:0] CH_0     = 6'd27;

  localparam logic [13:0] G_A = 14'b11101111000000;
  localparam logic [13:0] G_B = 14'b11110001010010;
  localparam logic [13:0] G_C = 14'b10011100000000;
  localparam logic [13:0] G_D = 14'b11110000010010;
  localparam logic [13:0] G_E = 14'b10011110000000;
  localparam logic [13:0] G_F = 14'b10001110000000;
  localparam logic [13:0] G_G = 14'b10111101000000;
  localparam logic [13:0] G_H = 14'b01101111000000;
  localparam logic [13:0] G_I = 14'b10010000010010;
  localparam logic [13:0] G_J = 14'b01111000000000;
  localparam logic [13:0] G_K = 14'b00001110001100;
  localparam logic [13:0] G_L = 14'b00011100000000;
  localparam logic [13:0] G_M = 14'b01101100101000;
  localparam logic [13:0] G_N = 14'b01101100100100;
  localparam logic [13:0] G_O = 14'b11111100000000;
  localparam logic [13:0] G_P = 14'b11001111000000;
  localparam logic [13:0] G_Q = 14'b11111100000100;
  localparam logic [13:0] G_R = 14'b11001111000100;
  localparam logic [13:0] G_S = 14'b10110111000000;
  localparam logic [13:0] G_T = 14'b10000000010010;
  localparam logic [13:0] G_U = 14'b01111100000000;
  localparam logic [13:0] G_V = 14'b00001100001001;
  localparam logic [13:0] G_W = 14'b01101100000101;
  localparam logic [13:0] G_X = 14'b00000000101101;
  localparam logic [13:0] G_Y = 14'b00000000101010;
  localparam logic [13:0] G_Z = 14'b10010000001001;
  localparam logic [13:0] G_0 = 14'b11111100001001;
  localparam logic [13:0] G_1 = 14'b01100000001000;
  localparam logic [13:0] G_2 = 14'b11011011000000;
  localparam logic [13:0] G_3 = 14'b11110001000000;
  localparam logic [13:0] G_4 = 14'b01100111000000;
  localparam logic [13:0] G_5 = 14'b10110111000000;
  localparam logic [13:0] G_6 = 14'b10111111000000;
  localparam logic [13:0] G_7 = 14'b11100000000000;
  localparam logic [13:0] G_8 = 14'b11111111000000;
  localparam logic [13:0] G_9 = 14'b11110111000000;

endpackage

// File: rtl/scroll_text14_font14.sv
// Combinational character-code to 14-segment glyph map.
// Codes 0 and 37-63 render blank.
module font14
  import scroll14_pkg::*;
(
  input  logic [5:0]  code,
  output logic [13:0] glyph
);

  always_comb begin
    glyph = '0;
    case (code)
      6'd1:  glyph = G_A;
      6'd2:  glyph = G_B;
      6'd3:  glyph = G_C;
      6'd4:  glyph = G_D;
      6'd5:  glyph = G_E;
      6'd6:  glyph = G_F;
      6'd7:  glyph = G_G;
      6'd8:  glyph = G_H;
      6'd9:  glyph = G_I;
      6'd10: glyph = G_J;
      6'd11: glyph = G_K;
      6'd12: glyph = G_L;
      6'd13: glyph = G_M;
      6'd14: glyph = G_N;
      6'd15: glyph = G_O;
      6'd16: glyph = G_P;
      6'd17: glyph = G_Q;
      6'd18: glyph = G_R;
      6'd19: glyph = G_S;
      6'd20: glyph = G_T;
      6'd21: glyph = G_U;
      6'd22: glyph = G_V;
      6'd23: glyph = G_W;
      6'd24: glyph = G_X;
      6'd25: glyph = G_Y;
      6'd26: glyph = G_Z;
      6'd27: glyph = G_0;
      6'd28: glyph = G_1;
      6'd29: glyph = G_2;
      6'd30: glyph = G_3;
      6'd31: glyph = G_4;
      6'd32: glyph = G_5;
      6'd33: glyph = G_6;
      6'd34: glyph = G_7;
      6'd35: glyph = G_8;
      6'd36: glyph = G_9;
      default: glyph = '0;
    endcase
  end

endmodule

// File: rtl/scroll_text14.sv
// Multiplexed 14-segment scrolling message display.
// Offset and length are latched per frame so a frame never tears.
module scroll_text14 #(
  parameter int DIGITS    = 12,
  parameter int MSG_DEPTH = 32,
  parameter int DIV_W     = 16
) (
`ifdef USE_POWER_PINS
  inout  wire               vdd,
  inout  wire               vss,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [5:0]        wr_char,
  input  logic [5:0]        msg_len,
  input  logic              scroll_en,
  input  logic [DIV_W-1:0]  step_div,
  output logic [DIGITS-1:0] sel,
  output logic [13:0]       segm,
  output logic              frame_start
);
  import scroll14_pkg::*;

  logic [5:0]       msg [MSG_DEPTH];
  logic             run;
  logic [3:0]       dig;
  logic [4:0]       offset;
  logic [4:0]       ptr;
  logic [5:0]       lf;
  logic [DIV_W-1:0] fcnt;

  logic [5:0]  len_c;
  logic        wrap;
  logic        step;
  logic [4:0]  off_nxt;
  logic [4:0]  ptr_inc;
  logic [13:0] glyph;

  font14 u_font (
    .code  (msg[ptr]),
    .glyph (glyph)
  );

  always_comb begin
    len_c   = (msg_len > 6'd32) ? 6'd32 : msg_len;
    wrap    = run && (dig == 4'(DIGITS - 1));
    step    = scroll_en && (fcnt >= step_div);
    off_nxt = offset;
    if (step) begin
      off_nxt = (({1'b0, offset} + 6'd1) >= len_c) ? 5'd0 : offset + 5'd1;
    end else if ({1'b0, offset} >= len_c) begin
      off_nxt = 5'd0;
    end
    ptr_inc = (({1'b0, ptr} + 6'd1) >= lf) ? 5'd0 : ptr + 5'd1;
  end

  // ptr walks the buffer alongside dig, wrapping at the frame length
  always_ff @(posedge clk) begin
    if (rst) begin
      run         <= 1'b0;
      dig         <= '0;
      offset      <= '0;
      ptr         <= '0;
      lf          <= '0;
      fcnt        <= '0;
      sel         <= '0;
      segm        <= '0;
      frame_start <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
      lf  <= len_c;
      ptr <= '0;
    end else begin
      sel         <= DIGITS'(1) << dig;
      segm        <= (lf == 6'd0) ? 14'd0 : glyph;
      frame_start <= (dig == 4'd0);
      if (wrap) begin
        dig    <= '0;
        offset <= off_nxt;
        ptr    <= off_nxt;
        lf     <= len_c;
        if (step) begin
          fcnt <= '0;
        end else if (scroll_en) begin
          fcnt <= fcnt + DIV_W'(1);
        end
      end else begin
        dig <= dig + 4'd1;
        ptr <= ptr_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg[i] <= CH_SPACE;
      end
    end else if (wr_en) begin
      msg[wr_addr] <= wr_char;
    end
  end

endmodule
